// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender (ZERO/SIGN/HIGH/SHAMT) with valid/ready handshake and flush.
// Define IMM_EXT_SKID_EN for a 2-entry skid buffer with registered in_ready; otherwise a single register stage.
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_neg
);

   typedef enum logic [1:0] {
      MODE_ZERO  = 2'd0,
      MODE_SIGN  = 2'd1,
      MODE_HIGH  = 2'd2,
      MODE_SHAMT = 2'd3
   } mode_e;

   logic [OUT_W-1:0] ext_data;
   logic             ext_neg;

   always_comb begin
      ext_data = '0;
      ext_neg  = 1'b0;
      case (mode_e'(in_mode))
         MODE_ZERO:  ext_data[IN_W-1:0] = in_imm;
         MODE_SIGN: begin
            ext_data = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
            ext_neg  = in_imm[IN_W-1];
         end
         MODE_HIGH:  ext_data[OUT_W-1 -: IN_W] = in_imm;
         MODE_SHAMT: ext_data[4:0] = in_imm[4:0];
         default:    ext_data = '0;
      endcase
   end

`ifdef IMM_EXT_SKID_EN

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e           state_q;
   logic             in_ready_q;
   logic [OUT_W-1:0] head_data_q, tail_data_q;
   logic             head_neg_q, tail_neg_q;

   // Head entry drives the output; tail only fills when the head is stalled.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, so branch order cannot leak state.
      if (rst) begin
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         // NOTE: the data registers are reset (not just the state) because out_data/out_neg must read 0 after reset.
         head_data_q <= '0;
         head_neg_q  <= 1'b0;
         tail_data_q <= '0;
         tail_neg_q  <= 1'b0;
      end else if (flush) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_valid) begin
                  head_data_q <= ext_data;
                  head_neg_q  <= ext_neg;
                  state_q     <= S_ONE;
               end
            end
            S_ONE: begin
               if (in_valid && out_ready) begin
                  head_data_q <= ext_data;
                  head_neg_q  <= ext_neg;
               end else if (in_valid) begin
                  tail_data_q <= ext_data;
                  tail_neg_q  <= ext_neg;
                  state_q     <= S_TWO;
                  in_ready_q  <= 1'b0;
               end else if (out_ready) begin
                  state_q <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (out_ready) begin
                  head_data_q <= tail_data_q;
                  head_neg_q  <= tail_neg_q;
                  state_q     <= S_ONE;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q    <= S_EMPTY;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != S_EMPTY);
   assign out_data  = head_data_q;
   assign out_neg   = head_neg_q;

`else

   logic             valid_q;
   logic [OUT_W-1:0] data_q;
   logic             neg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         neg_q   <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         valid_q <= 1'b1;
         data_q  <= ext_data;
         neg_q   <= ext_neg;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_neg   = neg_q;

`endif

endmodule
